// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants and types for the load/store control stage in front of the byte-addressed data RAM.
package mem_access_ctrl_pkg;

    localparam int W_DEF      = 32;
    localparam int ADDR_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    // RAM byte-mask encodings (BYTE / HALFWORD / FULLWORD)
    localparam logic [3:0] RAM_NONE     = 4'b0000;
    localparam logic [3:0] RAM_BYTE     = 4'b0001;
    localparam logic [3:0] RAM_HALFWORD = 4'b0011;
    localparam logic [3:0] RAM_FULLWORD = 4'b1111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // Offset from the first to the last byte touched for a given byte mask.
    function automatic logic [1:0] mask_extent(input logic [3:0] mask);
        logic [1:0] ext;
        case (mask)
            RAM_HALFWORD: ext = 2'd1;
            RAM_FULLWORD: ext = 2'd3;
            default:      ext = 2'd0;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request, RAM-side and writeback signals of the load/store control stage.
interface mem_access_ctrl_if #(
    parameter int W = 32
);
    logic         req_valid;
    logic         req_ready;
    logic         req_is_store;
    logic [2:0]   req_funct3;
    logic [W-1:0] req_base;
    logic [W-1:0] req_offset;
    logic [W-1:0] req_wdata;
    logic [4:0]   req_rd;

    logic [W-1:0] ram_addr;
    logic [W-1:0] ram_wdat;
    logic         ram_we;
    logic         ram_re;
    logic [3:0]   ram_type;
    logic         sign;
    logic [W-1:0] ram_rdata;

    logic         wb_valid;
    logic         wb_ready;
    logic [4:0]   wb_rd;
    logic [W-1:0] wb_data;
    logic         wb_fault;
    logic [1:0]   wb_cause;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
        input  ram_rdata, wb_ready,
        output req_ready, ram_addr, ram_wdat, ram_we, ram_re, ram_type, sign,
        output wb_valid, wb_rd, wb_data, wb_fault, wb_cause
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
        output ram_rdata, wb_ready,
        input  req_ready, ram_addr, ram_wdat, ram_we, ram_re, ram_type, sign,
        input  wb_valid, wb_rd, wb_data, wb_fault, wb_cause
    );

endinterface

// File: rtl/mem_access_ctrl_addr_check.sv
// Combinational size decode plus alignment and RAM-range check for one latched memory op.
module mem_addr_check
    import mem_access_ctrl_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [W-1:0] addr,
    input  logic [2:0]   funct3,
    input  logic         is_store,
    output logic [3:0]   ram_type,
    output logic         sign,
    output logic         fault,
    output logic [1:0]   cause
);

    logic         legal_s;
    logic [3:0]   mask_s;
    logic         misalign_s;
    logic         range_s;
    logic [W:0]   last_s;

    // Decode access size; illegal encodings report as misaligned.
    always_comb begin
        legal_s    = 1'b0;
        mask_s     = RAM_NONE;
        misalign_s = 1'b0;
        range_s    = 1'b0;
        last_s     = '0;
        case (funct3)
            F3_B:    begin legal_s = 1'b1;      mask_s = RAM_BYTE;     end
            F3_H:    begin legal_s = 1'b1;      mask_s = RAM_HALFWORD; end
            F3_W:    begin legal_s = 1'b1;      mask_s = RAM_FULLWORD; end
            F3_BU:   begin legal_s = !is_store; mask_s = RAM_BYTE;     end
            F3_HU:   begin legal_s = !is_store; mask_s = RAM_HALFWORD; end
            default: begin legal_s = 1'b0;      mask_s = RAM_NONE;     end
        endcase
        if (!legal_s) begin
            misalign_s = 1'b1;
        end else if (mask_s == RAM_HALFWORD) begin
            misalign_s = addr[0];
        end else if (mask_s == RAM_FULLWORD) begin
            misalign_s = (addr[1:0] != 2'b00);
        end else begin
            misalign_s = 1'b0;
        end
        // One extra bit so an access that wraps past 2**W also lands out of range.
        last_s  = {1'b0, addr} + {{(W - 1){1'b0}}, mask_extent(mask_s)};
        range_s = |last_s[W:ADDR_W];
    end

    // Fault priority and the strobes/mask presented to the RAM.
    always_comb begin
        fault    = misalign_s || range_s;
        cause    = CAUSE_NONE;
        ram_type = RAM_NONE;
        sign     = 1'b0;
        if (misalign_s) begin
            cause = CAUSE_MISALIGN;
        end else if (range_s) begin
            cause = CAUSE_RANGE;
        end else begin
            cause    = CAUSE_NONE;
            ram_type = mask_s;
            sign     = !is_store && !funct3[2];
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store control stage: accepts one op, does a single-cycle RAM access, then holds the result for writeback.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_ctrl_if.slave bus,
    output logic [CNT_W-1:0] cnt_load,
    output logic [CNT_W-1:0] cnt_store,
    output logic [CNT_W-1:0] cnt_fault
);

    state_t       state_r, state_s;
    logic [W-1:0] addr_r, wdata_r;
    logic [2:0]   funct3_r;
    logic         is_store_r;
    logic [4:0]   rd_r;

    logic [4:0]   wb_rd_r;
    logic [W-1:0] wb_data_r;
    logic         wb_fault_r;
    logic [1:0]   wb_cause_r;
    logic [CNT_W-1:0] cnt_load_r, cnt_store_r, cnt_fault_r;

    logic [3:0]   chk_type_s;
    logic         chk_sign_s, chk_fault_s;
    logic [1:0]   chk_cause_s;
    logic         in_access_s;

    mem_addr_check #(.W(W), .ADDR_W(ADDR_W)) u_check (
        .addr     (addr_r),
        .funct3   (funct3_r),
        .is_store (is_store_r),
        .ram_type (chk_type_s),
        .sign     (chk_sign_s),
        .fault    (chk_fault_s),
        .cause    (chk_cause_s)
    );

    // Everything below decodes from registers only, so async reset drops the strobes at once.
    assign in_access_s   = (state_r == ST_ACCESS);
    assign bus.req_ready = (state_r == ST_IDLE);
    assign bus.wb_valid  = (state_r == ST_RESP);
    assign bus.ram_we    = in_access_s && is_store_r && !chk_fault_s;
    assign bus.ram_re    = in_access_s && !is_store_r && !chk_fault_s;
    assign bus.ram_type  = in_access_s ? chk_type_s : RAM_NONE;
    assign bus.sign      = in_access_s && chk_sign_s;
    assign bus.ram_addr  = addr_r;
    assign bus.ram_wdat  = wdata_r;
    assign bus.wb_rd     = wb_rd_r;
    assign bus.wb_data   = wb_data_r;
    assign bus.wb_fault  = wb_fault_r;
    assign bus.wb_cause  = wb_cause_r;
    assign cnt_load      = cnt_load_r;
    assign cnt_store     = cnt_store_r;
    assign cnt_fault     = cnt_fault_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) state_s = ST_ACCESS;
                else               state_s = ST_IDLE;
            end
            ST_ACCESS: state_s = ST_RESP;
            ST_RESP: begin
                if (bus.wb_ready) state_s = ST_IDLE;
                else              state_s = ST_RESP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Request capture with effective-address computation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r     <= '0;
            wdata_r    <= '0;
            funct3_r   <= 3'd0;
            is_store_r <= 1'b0;
            rd_r       <= 5'd0;
        end else if ((state_r == ST_IDLE) && bus.req_valid) begin
            addr_r     <= bus.req_base + bus.req_offset;
            wdata_r    <= bus.req_wdata;
            funct3_r   <= bus.req_funct3;
            is_store_r <= bus.req_is_store;
            rd_r       <= bus.req_rd;
        end
    end

    // Result capture at the end of the access cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_rd_r    <= 5'd0;
            wb_data_r  <= '0;
            wb_fault_r <= 1'b0;
            wb_cause_r <= CAUSE_NONE;
        end else if (in_access_s) begin
            wb_fault_r <= chk_fault_s;
            wb_cause_r <= chk_cause_s;
            wb_rd_r    <= (chk_fault_s || is_store_r) ? 5'd0 : rd_r;
            wb_data_r  <= (chk_fault_s || is_store_r) ? '0 : bus.ram_rdata;
        end
    end

    // Saturating op counters, bumped on the writeback handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_load_r  <= '0;
            cnt_store_r <= '0;
            cnt_fault_r <= '0;
        end else if ((state_r == ST_RESP) && bus.wb_ready) begin
            if (wb_fault_r) begin
                if (cnt_fault_r != '1) cnt_fault_r <= cnt_fault_r + {{(CNT_W - 1){1'b0}}, 1'b1};
            end else if (is_store_r) begin
                if (cnt_store_r != '1) cnt_store_r <= cnt_store_r + {{(CNT_W - 1){1'b0}}, 1'b1};
            end else begin
                if (cnt_load_r != '1) cnt_load_r <= cnt_load_r + {{(CNT_W - 1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
